// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl: round-robin scan of NUM_BANKS sensor banks through one shared error detector,
// with per-bank debounce, sticky fault latches and a summary alarm.
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   enable     in   1 = scanning runs, 0 = return to IDLE
//   err_in     in   detector error for the currently selected bank
//   ack_mask   in   per-bank fault clear pulses
//   bank_sel   out  bank presented to the detector mux
//   fault      out  sticky latched fault per bank
//   alarm      out  OR of all fault bits
//   scan_done  out  1-cycle pulse after the last bank of a scan is sampled
module sensor_scan_ctrl #(
    parameter int NUM_BANKS  = 4,
    parameter int DEBOUNCE   = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         err_in,
    input  logic [NUM_BANKS-1:0]         ack_mask,
    output logic [$clog2(NUM_BANKS)-1:0] bank_sel,
    output logic [NUM_BANKS-1:0]         fault,
    output logic                         alarm,
    output logic                         scan_done
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [BW-1:0] LAST = BW'(NUM_BANKS - 1);
    localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE);
    localparam logic [SW-1:0] SEND = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

    state_t                       state, state_nx;
    logic [SW-1:0]                scnt;
    logic [NUM_BANKS-1:0][CW-1:0] cnt;
    logic [CW-1:0]                cur, cnt_nx;
    logic                         sample, last_sample;
    logic [BW-1:0]                sel_nx;
    logic [NUM_BANKS-1:0]         fault_set;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb
        state_nx = !enable         ? IDLE :
                   state == IDLE   ? SETTLE :
                   state == SETTLE ? (scnt == SEND ? SAMPLE : SETTLE) :
                                     SETTLE;

    // Only the selected bank's counter can change, so the debounce update
    // is computed once for bank_sel rather than per bank.
    always_comb begin
        sample      = state == SAMPLE;
        last_sample = sample && bank_sel == LAST;
        cur         = cnt[bank_sel];
        cnt_nx      = !err_in ? '0 : cur == DMAX ? cur : cur + 1'b1;
        fault_set   = (sample && cnt_nx == DMAX) ? NUM_BANKS'(1) << bank_sel : '0;
        sel_nx      = !enable ? '0 : sample ? (bank_sel == LAST ? '0 : bank_sel + 1'b1) : bank_sel;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            scnt      <= '0;
            bank_sel  <= '0;
            cnt       <= '0;
            fault     <= '0;
            scan_done <= 1'b0;
        end else begin
            scnt      <= state == SETTLE ? scnt + 1'b1 : '0;
            bank_sel  <= sel_nx;
            scan_done <= last_sample;
            if (sample) cnt[bank_sel] <= cnt_nx;
            // set is OR-ed after the clear so a simultaneous set wins
            fault     <= (fault & ~ack_mask) | fault_set;
        end

    assign alarm = |fault;
endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb_sensor_scan_ctrl: vector table, directed corner sequences and random stimulus against a position-based model
module tb_sensor_scan_ctrl;
    localparam int N = 4;
    localparam int D = 3;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         err_in = 1'b0;
    logic [N-1:0] ack_mask = '0;
    logic [1:0]   bank_sel;
    logic [N-1:0] fault;
    logic         alarm;
    logic         scan_done;

    int ncmp = 0;
    int nfail = 0;

    sensor_scan_ctrl #(.NUM_BANKS(N), .DEBOUNCE(D), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .enable(enable), .err_in(err_in), .ack_mask(ack_mask),
        .bank_sel(bank_sel), .fault(fault), .alarm(alarm), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // Reference model: scan position counted in cycles since scanning started.
    bit           m_act;
    int           m_pos;
    int           m_hits [N];
    logic [N-1:0] m_fault;
    bit           m_done;

    function automatic int m_sel();
        return m_act ? (m_pos / (S + 1)) % N : 0;
    endfunction

    task automatic model_reset();
        m_act = 0;
        m_pos = 0;
        m_fault = '0;
        m_done = 0;
        for (int i = 0; i < N; i++) m_hits[i] = 0;
    endtask

    task automatic model_edge();
        bit smp;
        int b;
        smp = m_act && (m_pos % (S + 1) == S);
        b = m_sel();
        m_done = smp && b == N - 1;
        m_fault = m_fault & ~ack_mask;
        if (smp) begin
            m_hits[b] = err_in ? (m_hits[b] < D ? m_hits[b] + 1 : D) : 0;
            if (m_hits[b] == D) m_fault[b] = 1'b1;
        end
        if (!enable) begin
            m_act = 0;
            m_pos = 0;
        end else if (!m_act) begin
            m_act = 1;
            m_pos = 0;
        end else m_pos++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("sel", 32'(bank_sel), 32'(m_sel()));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("alarm", 32'(alarm), 32'(|m_fault));
        chk("scan_done", 32'(scan_done), 32'(m_done));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        err_in = 1'b0;
        ack_mask = '0;
        model_reset();
        @(negedge clk);
        chk("rst_sel", 32'(bank_sel), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_done", 32'(scan_done), 0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic         en;
        logic         err;
        logic [N-1:0] ack;
        int           sel;
        logic [N-1:0] flt;
        logic         done;
    } vec_t;

    vec_t tbl [49];

    initial begin
        // Scan 1 error-free, then bank 2 errors on the next three bank-2 samples (edges 22, 34, 46).
        for (int k = 1; k <= 49; k++) begin
            tbl[k-1].en   = 1'b1;
            tbl[k-1].err  = (k >= 20 && k <= 22) || (k >= 32 && k <= 34) || (k >= 44 && k <= 46);
            tbl[k-1].ack  = '0;
            tbl[k-1].sel  = ((k - 1) / 3) % 4;
            tbl[k-1].flt  = k >= 46 ? 4'b0100 : 4'b0000;
            tbl[k-1].done = k > 1 && (k - 1) % 12 == 0;
        end

        do_reset();
        for (int k = 0; k < 49; k++) begin
            enable = tbl[k].en;
            err_in = tbl[k].err;
            ack_mask = tbl[k].ack;
            step();
            chk("tbl_sel", 32'(bank_sel), 32'(tbl[k].sel));
            chk("tbl_fault", 32'(fault), 32'(tbl[k].flt));
            chk("tbl_alarm", 32'(alarm), 32'(|tbl[k].flt));
            chk("tbl_done", 32'(scan_done), 32'(tbl[k].done));
        end

        // Bank 1: two hits, a clean sample, then three fresh hits.
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 69; k++) begin
            err_in = k == 7 || k == 19 || k == 43 || k == 55 || k == 67;
            enable = k < 68;
            step();
            if (k == 66) chk("deb_reset_fault", 32'(fault), 0);
            if (k == 67) chk("deb_fresh_fault", 32'(fault), 32'(4'b0010));
            if (k == 69) chk("dis_sel", 32'(bank_sel), 0);
            if (k == 69) chk("dis_fault", 32'(fault), 32'(4'b0010));
        end

        // Bank 2 persisting: ack on the setting edge, ack after set, then error removed.
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            err_in = k == 10 || k == 22 || k == 34 || k == 46;
            ack_mask = (k == 34 || k == 36 || k == 60) ? 4'b0100 : 4'b0000;
            step();
            if (k == 33) chk("pre_set_fault", 32'(fault), 0);
            if (k == 34) chk("set_wins", 32'(fault), 32'(4'b0100));
            if (k == 36 || k == 45) chk("ack_clear", 32'(fault), 0);
            if (k == 46) chk("reset_again", 32'(fault), 32'(4'b0100));
            if (k == 60 || k == 70) chk("ack_stays", 32'(fault), 0);
        end
        ack_mask = '0;

        // Faults on banks 1 and 3, then async reset mid-SETTLE of bank 3.
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 47; k++) begin
            err_in = k == 7 || k == 19 || k == 31 || k == 13 || k == 25 || k == 37;
            step();
            if (k == 37) chk("two_faults", 32'(fault), 32'(4'b1010));
            if (k == 47) chk("mid_settle_b3", 32'(bank_sel), 3);
        end
        rst = 1'b1;
        #1;
        chk("async_sel", 32'(bank_sel), 0);
        chk("async_fault", 32'(fault), 0);
        chk("async_alarm", 32'(alarm), 0);
        chk("async_done", 32'(scan_done), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        err_in = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            enable = j < 13;
            step();
            if (j == 3) chk("first_sample_b0", 32'(bank_sel), 0);
            if (j == 4) chk("after_b0_sample", 32'(bank_sel), 1);
            if (j == 13) chk("drop_done", 32'(scan_done), 1);
            if (j == 13) chk("drop_sel", 32'(bank_sel), 0);
            if (j == 14) chk("drop_done_once", 32'(scan_done), 0);
        end

        // Random stimulus with bank-dependent error rates.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            enable = $urandom_range(0, 49) != 0;
            err_in = $urandom_range(0, 99) < (m_sel() * 30 + 5);
            ack_mask = $urandom_range(0, 11) == 0 ? N'($urandom_range(0, 15)) : '0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
